// File: rtl/ddr3_client_arbiter_pkg.sv
// Shared types and constants for the DDR3 client arbiter.
// Optional build macro: ARB_WATCHDOG_EN (ownership watchdog in the top level).
package ddr3_client_arbiter_pkg;

    // Default DDR3 byte-address width used by the arbiter.
    localparam int DDR3_ADDR_W = 28;

    // Width of the ownership watchdog counter.
    localparam int WD_W = 16;

    // Arbiter FSM: IDLE picks a winner, OWN forwards the owner's traffic.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ddr3_client_arbiter_arb_pick.sv
// Combinational winner selection for the DDR3 client arbiter.
// RR_MODE = 0: lowest set request index wins.
// RR_MODE = 1: first set index strictly after 'last', wrapping upward.
module arb_pick #(
    parameter int N_CLIENTS = 4,
    parameter int RR_MODE   = 0,
    localparam int IW       = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [IW-1:0]        last,
    output logic [N_CLIENTS-1:0] winner,
    output logic                 valid
);

    logic [IW-1:0] cand;
    // 'last' only steers the search in round-robin mode.
    logic          unused_last;

    assign unused_last = ^last;

    // Scan candidates from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner = '0;
        valid  = |req;
        cand   = '0;
        if (RR_MODE == 0) begin
            for (int i = N_CLIENTS - 1; i >= 0; i--) begin
                cand = IW'(i);
                if (req[cand]) begin
                    winner       = '0;
                    winner[cand] = 1'b1;
                end
            end
        end else begin
            for (int off = N_CLIENTS; off >= 1; off--) begin
                cand = IW'((int'(last) + off) % N_CLIENTS);
                if (req[cand]) begin
                    winner       = '0;
                    winner[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr3_client_arbiter.sv
// Multi-client DDR3 bus arbiter: one owner at a time, no preemption,
// at least one IDLE cycle between grants. Owner's address/data/strobes are
// muxed onto the DDR3 side; a simultaneous rd+wr forwards only the read.
// Optional build macro: ARB_WATCHDOG_EN -- adds a 16-bit stall watchdog and
// the arb_timeout output; without it ownership is unbounded.
module ddr3_client_arbiter
    import ddr3_client_arbiter_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = DDR3_ADDR_W,
    parameter int RR_MODE   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIENTS-1:0]        cli_req,
    input  logic [N_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [N_CLIENTS-1:0]        cli_rd,
    input  logic [N_CLIENTS-1:0]        cli_wr,
    input  logic [N_CLIENTS*8-1:0]      cli_din,
    output logic [N_CLIENTS-1:0]        cli_grant,
    output logic [N_CLIENTS-1:0]        cli_ready,
    output logic [7:0]                  cli_dout,
    output logic [ADDR_W-1:0]           ddr3_addr,
    output logic                        ddr3_rd,
    output logic                        ddr3_wr,
    output logic [7:0]                  ddr3_din,
    output logic                        ddr3_request,
    input  logic [7:0]                  ddr3_dout,
    input  logic                        ddr3_ready,
`ifdef ARB_WATCHDOG_EN
    output logic                        arb_timeout,
`endif
    output arb_state_t                  dbg_state
);

    // Handshake: cli_req is a level held for the whole transfer sequence;
    // cli_rd/cli_wr are single-cycle strobes honoured only from the owner
    // (cli_grant bit set), and a strobe is accepted in the cycle where
    // cli_ready (ddr3_ready gated to the owner) is high. Strobes from
    // non-owners are dropped, never queued.

    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    arb_state_t           state_q, state_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [N_CLIENTS-1:0] elig_req;
    logic [N_CLIENTS-1:0] pick_winner;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        owner_idx;
    logic                 owner_req;
    logic                 owner_rd;
    logic                 owner_wr;
    logic                 wd_trip;

    arb_pick #(
        .N_CLIENTS (N_CLIENTS),
        .RR_MODE   (RR_MODE)
    ) u_pick (
        .req    (elig_req),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Encode the current owner and the fresh winner as indices.
    always_comb begin
        owner_idx = '0;
        pick_idx  = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant_q[i])     owner_idx = IW'(i);
            if (pick_winner[i]) pick_idx  = IW'(i);
        end
    end

    assign owner_req = cli_req[owner_idx];
    assign owner_rd  = cli_rd[owner_idx];
    assign owner_wr  = cli_wr[owner_idx];

`ifdef ARB_WATCHDOG_EN
    logic [WD_W-1:0]      wd_cnt_q;
    logic [N_CLIENTS-1:0] wd_mask_q;
    logic                 wd_pulse_q;

    assign wd_trip     = (state_q == OWN) && (wd_cnt_q == {WD_W{1'b1}});
    assign elig_req    = cli_req & ~wd_mask_q;
    assign arb_timeout = wd_pulse_q;

    // Count strobe-free OWN cycles; a trip evicts the owner and masks it until its req falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q   <= '0;
            wd_mask_q  <= '0;
            wd_pulse_q <= 1'b0;
        end else begin
            wd_pulse_q <= wd_trip;
            wd_mask_q  <= (wd_mask_q | (wd_trip ? grant_q : '0)) & cli_req;
            if (state_q != OWN || owner_rd || owner_wr || wd_trip) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end
`else
    assign wd_trip  = 1'b0;
    assign elig_req = cli_req;
`endif

    // FSM state, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_CLIENTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: grant from IDLE, release when the owner drops req.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    grant_d = pick_winner;
                    last_d  = pick_idx;
                end
            end
            OWN: begin
                if (!owner_req || wd_trip) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // DDR3-side mux: owner's signals in OWN, all zero in IDLE.
    always_comb begin
        ddr3_request = 1'b0;
        ddr3_addr    = '0;
        ddr3_din     = '0;
        ddr3_rd      = 1'b0;
        ddr3_wr      = 1'b0;
        if (state_q == OWN) begin
            ddr3_request = 1'b1;
            ddr3_addr    = cli_addr[int'(owner_idx)*ADDR_W +: ADDR_W];
            ddr3_din     = cli_din[int'(owner_idx)*8 +: 8];
            ddr3_rd      = owner_rd;
            ddr3_wr      = owner_wr & ~owner_rd;
        end
    end

    assign cli_grant = grant_q;
    assign cli_ready = grant_q & {N_CLIENTS{ddr3_ready}};
    assign cli_dout  = ddr3_dout;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr3_client_arbiter.sv
// Testbench for ddr3_client_arbiter: one fixed-priority and one round-robin
// instance; directed stimulus pushes expected grants / bus beats into queues
// that a negedge monitor pops whenever the DUT presents them.
// Optional build macro: ARB_WATCHDOG_EN (adds the watchdog scenario).
module tb_ddr3_client_arbiter;
    import ddr3_client_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 28;
    localparam int BW = AW + 8 + 1 + 1 + N;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic [N-1:0]    req_fix, req_rr;
    logic [N*AW-1:0] cli_addr;
    logic [N-1:0]    cli_rd, cli_wr;
    logic [N*8-1:0]  cli_din;
    logic [7:0]      ddr3_dout;
    logic            ddr3_ready;

    // ---------------- DUT outputs ----------------
    logic [N-1:0] g_fix, r_fix, g_rr, r_rr;
    logic [7:0]   dout_fix, dout_rr, din_fix, din_rr;
    logic [AW-1:0] addr_fix, addr_rr;
    logic         rd_fix, wr_fix, req_o_fix, rd_rr, wr_rr, req_o_rr;
    arb_state_t   st_fix, st_rr;
`ifdef ARB_WATCHDOG_EN
    logic         wd_fix, wd_rr;
`endif

    ddr3_client_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .RR_MODE(0)) dut_fix (
        .clk(clk), .reset(reset), .cli_req(req_fix), .cli_addr(cli_addr),
        .cli_rd(cli_rd), .cli_wr(cli_wr), .cli_din(cli_din),
        .cli_grant(g_fix), .cli_ready(r_fix), .cli_dout(dout_fix),
        .ddr3_addr(addr_fix), .ddr3_rd(rd_fix), .ddr3_wr(wr_fix), .ddr3_din(din_fix),
        .ddr3_request(req_o_fix), .ddr3_dout(ddr3_dout), .ddr3_ready(ddr3_ready),
`ifdef ARB_WATCHDOG_EN
        .arb_timeout(wd_fix),
`endif
        .dbg_state(st_fix)
    );

    ddr3_client_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .cli_req(req_rr), .cli_addr(cli_addr),
        .cli_rd(cli_rd), .cli_wr(cli_wr), .cli_din(cli_din),
        .cli_grant(g_rr), .cli_ready(r_rr), .cli_dout(dout_rr),
        .ddr3_addr(addr_rr), .ddr3_rd(rd_rr), .ddr3_wr(wr_rr), .ddr3_din(din_rr),
        .ddr3_request(req_o_rr), .ddr3_dout(ddr3_dout), .ddr3_ready(ddr3_ready),
`ifdef ARB_WATCHDOG_EN
        .arb_timeout(wd_rr),
`endif
        .dbg_state(st_rr)
    );

    // ---------------- scoreboard ----------------
    logic [N-1:0]  exp_gfix_q[$];
    logic [N-1:0]  exp_grr_q[$];
    logic [BW-1:0] exp_bus_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] beat(input logic [AW-1:0] a, input logic [7:0] d,
                                           input logic r, input logic w, input logic [N-1:0] rdy);
        return {a, d, r, w, rdy};
    endfunction

    // Monitor: pop an expectation whenever a grant changes or a DDR3 strobe appears.
    logic [N-1:0]  prev_fix, prev_rr;
    logic [BW-1:0] act_bus;
    always @(negedge clk) begin
        if (reset) begin
            prev_fix = '0;
            prev_rr  = '0;
        end else begin
            if (g_fix !== prev_fix) begin
                if (exp_gfix_q.size() == 0) check("fix_grant_unexpected", 64'(g_fix), 64'(prev_fix));
                else check("fix_grant", 64'(g_fix), 64'(exp_gfix_q.pop_front()));
                prev_fix = g_fix;
            end
            if (g_rr !== prev_rr) begin
                if (exp_grr_q.size() == 0) check("rr_grant_unexpected", 64'(g_rr), 64'(prev_rr));
                else check("rr_grant", 64'(g_rr), 64'(exp_grr_q.pop_front()));
                prev_rr = g_rr;
            end
            if (rd_fix || wr_fix) begin
                act_bus = {addr_fix, din_fix, rd_fix, wr_fix, r_fix};
                if (exp_bus_q.size() == 0) check("bus_unexpected", 64'(act_bus), 64'(0));
                else check("bus_beat", 64'(act_bus), 64'(exp_bus_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [N-1:0] rd, input logic [N-1:0] wr, input logic rdy);
        cli_rd     = rd;
        cli_wr     = wr;
        ddr3_ready = rdy;
        cycle(1);
        cli_rd     = '0;
        cli_wr     = '0;
        ddr3_ready = 1'b0;
    endtask

    logic [N-1:0] oh;
`ifdef ARB_WATCHDOG_EN
    int  waited;
    logic seen;
`endif

    initial begin
        reset = 1'b1;
        req_fix = '0; req_rr = '0; cli_rd = '0; cli_wr = '0;
        ddr3_ready = 1'b0; ddr3_dout = 8'hA5;
        cli_addr = {28'hFEDCBA9, 28'h1234567, 28'hAAAAAAA, 28'h0000100};
        cli_din  = {8'h44, 8'h33, 8'h11, 8'h77};

        // Reset state
        cycle(2);
        @(negedge clk);
        check("rst_grant", 64'(g_fix), 64'(0));
        check("rst_request", 64'(req_o_fix), 64'(0));
        check("rst_rdwr", 64'({rd_fix, wr_fix}), 64'(0));
        check("rst_addr", 64'(addr_fix), 64'(0));
        check("rst_state", 64'(st_fix), 64'(IDLE));
        check("cli_dout_passthru", 64'(dout_fix), 64'(8'hA5));
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(1);

        // Fixed priority: 1010 -> 0010, then 1000 after an IDLE gap
        req_fix = 4'b1010;
        exp_gfix_q.push_back(4'b0010);
        cycle(1);
        @(negedge clk);
        check("own_request", 64'(req_o_fix), 64'(1));
        check("own_state", 64'(st_fix), 64'(OWN));
        cycle(2);
        req_fix = 4'b1000;
        exp_gfix_q.push_back(4'b0000);
        exp_gfix_q.push_back(4'b1000);
        cycle(1);
        @(negedge clk);
        check("idle_request", 64'(req_o_fix), 64'(0));
        check("idle_addr_din", 64'({addr_fix, din_fix}), 64'(0));
        cycle(3);
        req_fix = 4'b0000;
        exp_gfix_q.push_back(4'b0000);
        cycle(2);

        // Owner 2: no preemption by client 0, non-owner strobes dropped, rd wins over wr
        req_fix = 4'b0100;
        exp_gfix_q.push_back(4'b0100);
        cycle(1);
        req_fix = 4'b0101;
        exp_bus_q.push_back(beat(28'h1234567, 8'h33, 1'b1, 1'b0, 4'b0100));
        strobe(4'b0100, 4'b0001, 1'b1);
        cli_din[2*8 +: 8] = 8'h5A;
        exp_bus_q.push_back(beat(28'h1234567, 8'h5A, 1'b1, 1'b0, 4'b0100));
        strobe(4'b0100, 4'b0100, 1'b1);
        cli_din[2*8 +: 8] = 8'hC3;
        exp_bus_q.push_back(beat(28'h1234567, 8'hC3, 1'b0, 1'b1, 4'b0000));
        strobe(4'b0000, 4'b0101, 1'b0);
        cycle(2);
        req_fix = 4'b0001;
        exp_gfix_q.push_back(4'b0000);
        exp_gfix_q.push_back(4'b0001);
        cycle(2);
        exp_bus_q.push_back(beat(28'h0000100, 8'h77, 1'b0, 1'b1, 4'b0001));
        strobe(4'b0000, 4'b0001, 1'b1);
        req_fix = 4'b0000;
        exp_gfix_q.push_back(4'b0000);
        cycle(2);

        // Request dropped before grant loses its claim; idle strobes ignored
        req_fix = 4'b0001;
        exp_gfix_q.push_back(4'b0001);
        cycle(1);
        req_fix = 4'b0011;
        cycle(1);
        req_fix = 4'b0001;
        cycle(1);
        req_fix = 4'b0000;
        exp_gfix_q.push_back(4'b0000);
        cycle(2);
        strobe(4'b0010, 4'b0001, 1'b1);
        cycle(2);
        @(negedge clk);
        check("no_latched_claim", 64'(g_fix), 64'(0));

        // Round-robin: all requesting, each owner releases after 3 cycles
        cycle(1);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            exp_grr_q.push_back(oh);
            exp_grr_q.push_back(4'b0000);
            req_rr = 4'b1111;
            cycle(3);
            req_rr = 4'b1111 & ~oh;
            cycle(1);
        end
        req_rr = 4'b0000;
        cycle(2);

        // Reset mid-OWN: asynchronous clear, then client 0 wins first
        req_fix = 4'b1100;
        req_rr  = 4'b0100;
        exp_gfix_q.push_back(4'b0100);
        exp_grr_q.push_back(4'b0100);
        cycle(2);
        #1 reset = 1'b1;
        #1;
        check("async_rst_grant_fix", 64'(g_fix), 64'(0));
        check("async_rst_request_fix", 64'(req_o_fix), 64'(0));
        check("async_rst_grant_rr", 64'(g_rr), 64'(0));
        check("async_rst_request_rr", 64'(req_o_rr), 64'(0));
        req_fix = 4'b1111;
        req_rr  = 4'b1111;
        exp_gfix_q.push_back(4'b0001);
        exp_grr_q.push_back(4'b0001);
        #4 reset = 1'b0;
        cycle(2);
        req_fix = 4'b0000;
        req_rr  = 4'b0000;
        exp_gfix_q.push_back(4'b0000);
        exp_grr_q.push_back(4'b0000);
        cycle(2);

`ifdef ARB_WATCHDOG_EN
        // Watchdog: stalled owner 0 is evicted, client 1 takes over, 0 masked until req toggles
        req_fix = 4'b0011;
        exp_gfix_q.push_back(4'b0001);
        exp_gfix_q.push_back(4'b0000);
        exp_gfix_q.push_back(4'b0010);
        cycle(1);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 70000) begin
            @(negedge clk);
            if (wd_fix) seen = 1'b1;
            else waited++;
        end
        check("wd_timeout_seen", 64'(seen), 64'(1));
        @(negedge clk);
        check("wd_pulse_width", 64'(wd_fix), 64'(0));
        @(posedge clk); #1;
        req_fix = 4'b0001;
        exp_gfix_q.push_back(4'b0000);
        cycle(6);
        req_fix = 4'b0000;
        cycle(1);
        req_fix = 4'b0001;
        exp_gfix_q.push_back(4'b0001);
        cycle(2);
        req_fix = 4'b0000;
        exp_gfix_q.push_back(4'b0000);
        cycle(2);
`endif

        // Final report
        cycle(3);
        check("fix_grant_queue_drained", 64'(exp_gfix_q.size()), 64'(0));
        check("rr_grant_queue_drained", 64'(exp_grr_q.size()), 64'(0));
        check("bus_queue_drained", 64'(exp_bus_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
